seq_scan_ctrl: RTL

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: shifts a captured word MSB-first into an external
// 11101 Mealy detector and records hit count and first hit position.
module seq_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic             det_hit,
  output logic             det_rst,
  output logic             det_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_valid,
  output logic [POS_W-1:0] first_pos
);

  // state   | meaning
  // S_IDLE  | waiting for start; results from last scan held
  // S_CLEAR | one-cycle synchronous clear of the detector
  // S_SHIFT | one data bit per cycle into the detector, hits counted
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [POS_W-1:0] bit_idx;
  logic             load;
  logic             shift_en;
  logic             det_rst_fsm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    det_in      = 1'b0;
    det_rst_fsm = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    case (state)
      S_IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          load      = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy        = 1'b1;
        det_rst_fsm = 1'b1;
        state_nxt   = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        det_in = shift_reg[WIDTH-1];
        if (abort) begin
          det_rst_fsm = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          shift_en = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Detector is held in clear for as long as the controller is in reset.
  assign det_rst = !rst || det_rst_fsm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else if (load) begin
      shift_reg <= data_in;
      bit_idx   <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_reg << 1;
      bit_idx   <= bit_idx + 1'b1;
    end
  end

  // Hit results are only touched on a new start or a non-aborted shift, so
  // they hold partial values after an abort and final values after done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count <= '0;
      hit_valid <= 1'b0;
      first_pos <= '0;
    end else if (load) begin
      hit_count <= '0;
      hit_valid <= 1'b0;
      first_pos <= '0;
    end else if (shift_en && det_hit) begin
      if (hit_count != CNT_MAX) begin
        hit_count <= hit_count + 1'b1;
      end
      if (!hit_valid) begin
        hit_valid <= 1'b1;
        first_pos <= bit_idx;
      end
    end
  end

endmodule
